serial_async_tx_core: RTL and testbench



---
 rtl/serial_pkg.sv | 16 +
 rtl/serial_baud_tick.sv | 30 +++
 rtl/serial_async_tx_core.sv | 102 ++++++++++
 tb/tb_serial_async_tx_core.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - Shared state encoding and divider helper for the serial TX/RX cores
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  function automatic int unsigned calc_clk_div(input int unsigned main_hz,
                                               input int unsigned serial_hz);
    return main_hz / serial_hz;
  endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// rtl/serial_baud_tick.sv - Bit-period counter: tick on the last cycle of each DIV-cycle period
module serial_baud_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_clear,
  output logic out_tick,
  output logic out_first
);

  localparam int unsigned W = $clog2(DIV) + 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (in_clear || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign out_tick  = (cnt_q == LAST);
  assign out_first = (cnt_q == '0);

endmodule

// File: rtl/serial_async_tx_core.sv
// rtl/serial_async_tx_core.sv - UART-style transmitter: start, BITS data, one stop, zero-gap streaming
module serial_async_tx_core
  import serial_pkg::*;
#(
  parameter int unsigned BITS          = 8,
  parameter bit          LOWBIT_FIRST  = 1'b1,
  parameter int unsigned MAIN_CLK_HZ   = 50_000_000,
  parameter int unsigned SERIAL_CLK_HZ = 9600
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_enable,
  input  logic [BITS-1:0] in_parallel,
  output logic            out_serial,
  output logic            out_next_word,
  output logic            out_ready
);

  localparam int unsigned CLK_DIV = calc_clk_div(MAIN_CLK_HZ, SERIAL_CLK_HZ);
  localparam int unsigned BW = $clog2(BITS) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);

  tx_state_e       state_q, state_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            tick, first;
  logic            tx_bit;

  // Counter held clear while idle so every frame starts on a fresh bit period.
  serial_baud_tick #(.DIV(CLK_DIV)) u_baud (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_clear (state_q == ST_IDLE),
    .out_tick (tick),
    .out_first(first)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_enable) begin
          state_d   = ST_START;
          shift_d   = in_parallel;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = LOWBIT_FIRST ? (shift_q >> 1) : (shift_q << 1);
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Enable is only honoured on the last stop cycle, giving back-to-back frames.
        if (tick) begin
          if (in_enable) begin
            state_d   = ST_START;
            shift_d   = in_parallel;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign tx_bit = LOWBIT_FIRST ? shift_q[0] : shift_q[BITS-1];

  always_comb begin
    out_serial = 1'b1;
    case (state_q)
      ST_START: out_serial = 1'b0;
      ST_DATA:  out_serial = tx_bit;
      default:  out_serial = 1'b1;
    endcase
  end

  assign out_ready     = (state_q == ST_IDLE);
  assign out_next_word = (state_q == ST_STOP) && first;

endmodule

// File: tb/tb_serial_async_tx_core.sv
// tb/tb_serial_async_tx_core.sv - Scoreboard bench for serial_async_tx_core (CLK_DIV=4 LSB-first, CLK_DIV=1 MSB-first)
module tb_serial_async_tx_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, men;
  logic [7:0] par, mpar;
  logic       ser, nw, rdy;
  logic       mser, mnw, mrdy;
  logic [2:0] q[$];
  logic [2:0] mq[$];
  int         passed = 0;
  int         total = 0;

  always #5 clk = ~clk;

  serial_async_tx_core #(
    .BITS(8), .LOWBIT_FIRST(1'b1), .MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(250_000)
  ) dut (
    .in_clk(clk), .in_rst(rst_n), .in_enable(en), .in_parallel(par),
    .out_serial(ser), .out_next_word(nw), .out_ready(rdy)
  );

  serial_async_tx_core #(
    .BITS(8), .LOWBIT_FIRST(1'b0), .MAIN_CLK_HZ(1_000_000), .SERIAL_CLK_HZ(1_000_000)
  ) dut_msb (
    .in_clk(clk), .in_rst(rst_n), .in_enable(men), .in_parallel(mpar),
    .out_serial(mser), .out_next_word(mnw), .out_ready(mrdy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {serial, next_word, ready} per cycle for one frame.
  task automatic push_frame(input logic [7:0] w, input bit msb);
    logic b;
    int   div;
    div = msb ? 1 : 4;
    for (int s = 0; s < 10; s++) begin
      if (s == 0)      b = 1'b0;
      else if (s == 9) b = 1'b1;
      else             b = msb ? w[8-s] : w[s-1];
      for (int c = 0; c < div; c++) begin
        if (msb) mq.push_back({b, (s == 9 && c == 0), 1'b0});
        else     q.push_back({b, (s == 9 && c == 0), 1'b0});
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; men = 1'b0; par = 8'h00; mpar = 8'h00;
    step(); step();
    total++;
    if ({ser, nw, rdy} !== 3'b101) $display("FAIL reset_hold: got %b want 101", {ser, nw, rdy});
    else passed++;
    total++;
    if ({mser, mnw, mrdy} !== 3'b101) $display("FAIL reset_hold_msb: got %b want 101", {mser, mnw, mrdy});
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({ser, nw, rdy} !== 3'b101) $display("FAIL reset_release c%0d: got %b want 101", i, {ser, nw, rdy});
      else passed++;
    end
  endtask

  task automatic test_single();
    logic [2:0] e;
    int pulses = 0;
    step(); en = 1'b1; par = 8'h10;
    push_frame(8'h10, 1'b0); q.push_back(3'b101);
    step(); en = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if ({ser, nw, rdy} !== e) $display("FAIL single: got %b want %b", {ser, nw, rdy}, e);
      else passed++;
      if (nw) pulses++;
      if (q.size() > 0) step();
    end
    total++;
    if (pulses !== 1) $display("FAIL single_pulses: got %0d want 1", pulses);
    else passed++;
  endtask

  task automatic test_stream();
    logic [7:0] words [4];
    logic [2:0] e;
    int pulses = 0, busy = 0;
    bit restore = 1'b0;
    words = '{8'h10, 8'h01, 8'h11, 8'hFF};
    step(); en = 1'b1; par = words[0];
    for (int i = 0; i < 4; i++) push_frame(words[i], 1'b0);
    q.push_back(3'b101);
    step();
    while (q.size() > 0) begin
      if (restore) begin en = 1'b1; restore = 1'b0; end
      e = q.pop_front(); total++;
      if ({ser, nw, rdy} !== e) $display("FAIL stream: got %b want %b", {ser, nw, rdy}, e);
      else passed++;
      if (!rdy) busy++;
      if (nw) begin
        pulses++;
        if (pulses < 4) par = words[pulses];
        if (pulses == 2) begin en = 1'b0; restore = 1'b1; end
        if (pulses == 4) en = 1'b0;
      end
      if (q.size() > 0) step();
    end
    total++;
    if (pulses !== 4) $display("FAIL stream_pulses: got %0d want 4", pulses);
    else passed++;
    total++;
    if (busy !== 160) $display("FAIL stream_busy: got %0d want 160", busy);
    else passed++;
  endtask

  task automatic test_msb_div1();
    logic [2:0] e;
    int pulses = 0;
    step(); men = 1'b1; mpar = 8'h01;
    push_frame(8'h01, 1'b1); push_frame(8'hB4, 1'b1); mq.push_back(3'b101);
    step();
    while (mq.size() > 0) begin
      e = mq.pop_front(); total++;
      if ({mser, mnw, mrdy} !== e) $display("FAIL msb_div1: got %b want %b", {mser, mnw, mrdy}, e);
      else passed++;
      if (mnw) begin
        pulses++;
        if (pulses == 1) mpar = 8'hB4;
        else men = 1'b0;
      end
      if (mq.size() > 0) step();
    end
    total++;
    if (pulses !== 2) $display("FAIL msb_pulses: got %0d want 2", pulses);
    else passed++;
  endtask

  task automatic test_disturb();
    logic [2:0] e;
    int cyc = 0;
    step(); en = 1'b1; par = 8'hA5;
    push_frame(8'hA5, 1'b0); q.push_back(3'b101); q.push_back(3'b101);
    step();
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if ({ser, nw, rdy} !== e) $display("FAIL disturb c%0d: got %b want %b", cyc, {ser, nw, rdy}, e);
      else passed++;
      if (cyc == 12) begin par = 8'h3C; en = 1'b0; end
      cyc++;
      if (q.size() > 0) step();
    end
  endtask

  task automatic test_reset_midframe();
    logic [2:0] e;
    step(); en = 1'b1; par = 8'h55;
    push_frame(8'h55, 1'b0);
    step(); en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      e = q.pop_front(); total++;
      if ({ser, nw, rdy} !== e) $display("FAIL pre_reset c%0d: got %b want %b", c, {ser, nw, rdy}, e);
      else passed++;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ser, nw, rdy} !== 3'b101) $display("FAIL async_reset: got %b want 101", {ser, nw, rdy});
    else passed++;
    q.delete();
    step(); rst_n = 1'b1;
    step(); en = 1'b1; par = 8'h96;
    push_frame(8'h96, 1'b0); q.push_back(3'b101);
    step(); en = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front(); total++;
      if ({ser, nw, rdy} !== e) $display("FAIL post_reset: got %b want %b", {ser, nw, rdy}, e);
      else passed++;
      if (q.size() > 0) step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_msb_div1();
    test_disturb();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
